// File: rtl/multi_timer.sv
// Multi-channel programmable timer: per-channel reload/mode registers, gated phase counters
// and registered waveform outputs. Define MULTI_TIMER_IRQ_EN to build the terminal-count irq logic.
module multi_timer #(
    parameter int NCH = 2,
    parameter int CW  = 8,
    parameter int AW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [AW-1:0]  addr,
    input  logic [CW-1:0]  wdata,
    output logic [CW-1:0]  rdata,
    input  logic [NCH-1:0] gate,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] irq
);

    logic [NCH-1:0][CW-1:0] phase_all;
    logic [NCH-1:0][2:0]    mode_all;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] n_reg;
            logic [CW-1:0] phase_reg;
            logic [CW-1:0] phase_next;
            logic [2:0]    mode_reg;
            logic          gate_prev_reg;
            logic          done_reg;
            logic          done_next;
            logic          out_reg;
            logic          out_next;
            logic          wr_reload;
            logic          wr_mode;
            logic          valid;
            logic          restart;
            logic          at_end;
            logic          wave;
            logic [CW-1:0] n_minus1;
            logic [CW-1:0] half_n;

            assign wr_reload = wr_en && (addr == AW'(2 * gi));
            assign wr_mode   = wr_en && (addr == AW'(2 * gi + 1));
            assign valid     = (n_reg >= CW'(2));
            assign restart   = (gate[gi] && !gate_prev_reg) || wr_reload || wr_mode;
            assign n_minus1  = n_reg - CW'(1);
            // ceil(n/2) computed without an extra carry bit: floor(n/2) + lsb never overflows
            assign half_n    = (n_reg >> 1) + {{(CW-1){1'b0}}, n_reg[0]};
            assign at_end    = (phase_reg >= n_minus1);

            always_comb begin
                wave = 1'b0;
                case (mode_reg)
                    3'd0:    wave = at_end;
                    3'd1:    wave = (phase_reg != '0);
                    3'd2:    wave = (phase_reg >= half_n);
                    3'd3:    wave = !at_end && !done_reg;
                    default: wave = 1'b0;
                endcase
            end

            // A restart aborts the current period, so the output drops for that edge
            always_comb begin
                phase_next = phase_reg;
                done_next  = done_reg;
                out_next   = 1'b0;
                if (!valid || restart) begin
                    phase_next = '0;
                    done_next  = 1'b0;
                end else if (gate[gi]) begin
                    out_next = wave;
                    if (mode_reg == 3'd3) begin
                        if (at_end)
                            done_next = 1'b1;
                        else
                            phase_next = phase_reg + CW'(1);
                    end else begin
                        phase_next = at_end ? '0 : phase_reg + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    n_reg         <= '0;
                    mode_reg      <= '0;
                    phase_reg     <= '0;
                    gate_prev_reg <= 1'b0;
                    done_reg      <= 1'b0;
                    out_reg       <= 1'b0;
                end else begin
                    if (wr_reload)
                        n_reg <= wdata;
                    if (wr_mode)
                        mode_reg <= wdata[2:0];
                    phase_reg     <= phase_next;
                    done_reg      <= done_next;
                    out_reg       <= out_next;
                    gate_prev_reg <= gate[gi];
                end
            end

            assign out[gi]       = out_reg;
            assign phase_all[gi] = phase_reg;
            assign mode_all[gi]  = mode_reg;

`ifdef MULTI_TIMER_IRQ_EN
            logic irq_reg;
            logic irq_next;

            // One pulse per period; in one-shot mode only until done latches
            assign irq_next = valid && !restart && gate[gi] && at_end &&
                              ((mode_reg != 3'd3) || !done_reg);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    irq_reg <= 1'b0;
                else
                    irq_reg <= irq_next;
            end

            assign irq[gi] = irq_reg;
`else
            assign irq[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (addr == AW'(2 * k))
                rdata = phase_all[k];
            else if (addr == AW'(2 * k + 1))
                rdata = {{(CW-3){1'b0}}, mode_all[k]};
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed testbench for multi_timer (NCH=2, CW=8, AW=2) with hand-computed expected waveforms.
module tb_multi_timer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic [1:0] gate  = '0;
    logic [1:0] out;
    logic [1:0] irq;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MULTI_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    multi_timer #(.NCH(2), .CW(8), .AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .gate  (gate),
        .out   (out),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_out", out, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // ch0 mode 0, n=5: one high every 5 cycles
        wr(2'd0, 8'd5);
        wr(2'd1, 8'd0);
        gate[0] = 1'b1;
        addr    = 2'd0;
        tick();
        check("m0_restart_out", out[0], 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("m0_out_k%0d", k), out[0], ((k - 1) % 5) == 4);
            check($sformatf("m0_irq_k%0d", k), irq[0], IRQ_ON && (((k - 1) % 5) == 4));
            check($sformatf("m0_phase_k%0d", k), rdata, k % 5);
        end
        gate[0] = 1'b0;
        tick();
        check("m0_gatelow_out", out[0], 0);
        check("m0_gatelow_phase", rdata, 2);

        // ch1 mode 2, n=7: 4 low, 3 high
        wr(2'd2, 8'd7);
        wr(2'd3, 8'd2);
        gate[1] = 1'b1;
        addr    = 2'd2;
        tick();
        check("m2_restart_out", out[1], 0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("m2_out_k%0d", k), out[1], ((k - 1) % 7) >= 4);
            check($sformatf("m2_phase_k%0d", k), rdata, k % 7);
        end
        addr = 2'd0;
        #1;
        check("indep_ch0_phase", rdata, 2);
        addr = 2'd1;
        #1;
        check("rd_mode0", rdata, 0);
        addr = 2'd3;
        #1;
        check("rd_mode1", rdata, 2);
        check("indep_ch0_out", out[0], 0);

        // ch0 one-shot, n=4: 3 high then low; re-armed by gate rise
        wr(2'd0, 8'd4);
        wr(2'd1, 8'd3);
        gate[0] = 1'b1;
        addr    = 2'd0;
        tick();
        check("m3_restart_out", out[0], 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("m3_out_k%0d", k), out[0], k <= 3);
            check($sformatf("m3_irq_k%0d", k), irq[0], IRQ_ON && (k == 4));
            check($sformatf("m3_phase_k%0d", k), rdata, (k <= 3) ? k : 3);
        end
        gate[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("m3_idle_out_k%0d", k), out[0], 0);
        end
        gate[0] = 1'b1;
        tick();
        check("m3_rearm_out", out[0], 0);
        check("m3_rearm_phase", rdata, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("m3b_out_k%0d", k), out[0], k <= 3);
        end

        // ch1 mode 1, n=6: gate dropped at phase 3, restart on rise
        wr(2'd2, 8'd6);
        wr(2'd3, 8'd1);
        addr = 2'd2;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("m1_phase_k%0d", k), rdata, k);
            check($sformatf("m1_out_k%0d", k), out[1], k >= 2);
        end
        gate[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("m1_frz_out_k%0d", k), out[1], 0);
            check($sformatf("m1_frz_phase_k%0d", k), rdata, 3);
        end
        gate[1] = 1'b1;
        tick();
        check("m1_rise_phase", rdata, 0);
        check("m1_rise_out", out[1], 0);
        tick();
        check("m1_p1_phase", rdata, 1);
        check("m1_p1_out", out[1], 0);
        tick();
        check("m1_p2_phase", rdata, 2);
        check("m1_p2_out", out[1], 1);

        // invalid reloads on ch1
        wr(2'd2, 8'd1);
        tick();
        check("n1_out", out[1], 0);
        check("n1_phase", rdata, 0);
        wr(2'd2, 8'd0);
        tick();
        check("n0_out", out[1], 0);
        check("n0_phase", rdata, 0);

        // ch0 mode 0, n=3 irq cadence, then async reset mid-period
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd0);
        addr = 2'd0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("n3_out_k%0d", k), out[0], ((k - 1) % 3) == 2);
            check($sformatf("n3_irq_k%0d", k), irq[0], IRQ_ON && (((k - 1) % 3) == 2));
            check($sformatf("n3_ch1_out_k%0d", k), out[1], 0);
        end
        rst_n = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_irq", irq, 0);
        check("arst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("post_rst_out_k%0d", k), out, 0);
            check($sformatf("post_rst_phase_k%0d", k), rdata, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
